// File: rtl/result_reader.sv
// rtl/result_reader.sv - result memory read-back master streaming decoded records into the host output FIFO
// Optional macro RESULT_STATS_EN adds per-run fail and timeout counters.
module result_reader #(
  parameter int ADDR_WIDTH  = 20,
  parameter int DATA_WIDTH  = 16,
  parameter int BE_WIDTH    = DATA_WIDTH/8,
  parameter int RTF_WIDTH   = 24,
  parameter int CYCLE_RANGE = 5,
  parameter int CNT_WIDTH   = 16,
  parameter int OUT_WIDTH   = RTF_WIDTH+CYCLE_RANGE+2
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_address,
  input  logic [CNT_WIDTH-1:0]  num_records,
  output logic                  busy,
  output logic                  done,
  output logic                  end_marker,
  output logic [CNT_WIDTH-1:0]  records_done,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [BE_WIDTH-1:0]   mem_byteenable,
  output logic                  mem_read,
  input  logic [DATA_WIDTH-1:0] mem_readdata,
  input  logic                  mem_waitrequest,
  output logic [OUT_WIDTH-1:0]  ofifo_data,
  output logic                  ofifo_wrreq,
  input  logic                  ofifo_full,
  output logic [CNT_WIDTH-1:0]  fail_count,
  output logic [CNT_WIDTH-1:0]  timeout_count
);

  localparam int META_WIDTH = DATA_WIDTH/2;

  typedef enum logic [2:0] {IDLE, RD_W0, RD_W1, PUSH, FINISH} state_t;

  state_t                state, state_next;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [CNT_WIDTH-1:0]  remaining_q;
  logic [CNT_WIDTH-1:0]  records_q;
  logic [DATA_WIDTH-1:0] word0_q;
  logic [DATA_WIDTH-1:0] word1_q;
  logic                  end_marker_q;
  logic                  run_bit;
  logic                  timeout_bit;
  logic                  fail_bit;
  logic                  launch;

  // meta occupies the low half of word1: {run, timeout, cycle_count, fail}
  assign run_bit     = word1_q[CYCLE_RANGE+2];
  assign timeout_bit = word1_q[CYCLE_RANGE+1];
  assign fail_bit    = word1_q[0];
  assign launch      = (state == IDLE) && start;

  assign ofifo_data = {timeout_bit, word1_q[CYCLE_RANGE:1], fail_bit,
                       word0_q, word1_q[DATA_WIDTH-1:META_WIDTH]};

  assign busy           = (state != IDLE);
  assign end_marker     = end_marker_q;
  assign records_done   = records_q;
  assign mem_address    = addr_q;
  assign mem_byteenable = '1;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next  = state;
    mem_read    = 1'b0;
    ofifo_wrreq = 1'b0;
    done        = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = (num_records != '0) ? RD_W0 : FINISH;
      end
      RD_W0: begin
        mem_read = 1'b1;
        if (!mem_waitrequest) state_next = RD_W1;
      end
      RD_W1: begin
        mem_read = 1'b1;
        if (!mem_waitrequest) state_next = PUSH;
      end
      PUSH: begin
        if (!run_bit) begin
          state_next = FINISH;
        end else if (!ofifo_full) begin
          ofifo_wrreq = 1'b1;
          state_next  = (remaining_q > CNT_WIDTH'(1)) ? RD_W0 : FINISH;
        end
      end
      FINISH: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      addr_q       <= '0;
      remaining_q  <= '0;
      records_q    <= '0;
      word0_q      <= '0;
      word1_q      <= '0;
      end_marker_q <= 1'b0;
    end else begin
      if (launch) begin
        addr_q       <= base_address;
        remaining_q  <= num_records;
        records_q    <= '0;
        end_marker_q <= 1'b0;
      end
      if (mem_read && !mem_waitrequest) begin
        addr_q <= addr_q + ADDR_WIDTH'(1);
        if (state == RD_W0) word0_q <= mem_readdata;
        else                word1_q <= mem_readdata;
      end
      if (state == PUSH && !run_bit) end_marker_q <= 1'b1;
      if (ofifo_wrreq) begin
        remaining_q <= remaining_q - CNT_WIDTH'(1);
        if (records_q != '1) records_q <= records_q + CNT_WIDTH'(1);
      end
    end
  end

`ifdef RESULT_STATS_EN
  logic [CNT_WIDTH-1:0] fail_q;
  logic [CNT_WIDTH-1:0] timeout_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fail_q    <= '0;
      timeout_q <= '0;
    end else if (launch) begin
      fail_q    <= '0;
      timeout_q <= '0;
    end else if (ofifo_wrreq) begin
      if (fail_bit && fail_q != '1)       fail_q    <= fail_q + CNT_WIDTH'(1);
      if (timeout_bit && timeout_q != '1) timeout_q <= timeout_q + CNT_WIDTH'(1);
    end
  end

  assign fail_count    = fail_q;
  assign timeout_count = timeout_q;
`else
  assign fail_count    = '0;
  assign timeout_count = '0;
`endif

endmodule

// File: tb/tb_result_reader.sv
// tb/tb_result_reader.sv - self-checking bench for result_reader against a record-level memory model
module tb_result_reader;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [19:0] base_address = '0;
  logic [15:0] num_records = '0;
  logic        busy, done, end_marker, mem_read, ofifo_wrreq;
  logic [15:0] records_done, fail_count, timeout_count;
  logic [19:0] mem_address;
  logic [1:0]  mem_byteenable;
  logic [15:0] mem_readdata = '0;
  logic        mem_waitrequest = 1'b0;
  logic [30:0] ofifo_data;
  logic        ofifo_full = 1'b0;

  result_reader dut (
    .clock(clock), .reset_n(reset_n), .start(start),
    .base_address(base_address), .num_records(num_records),
    .busy(busy), .done(done), .end_marker(end_marker), .records_done(records_done),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable), .mem_read(mem_read),
    .mem_readdata(mem_readdata), .mem_waitrequest(mem_waitrequest),
    .ofifo_data(ofifo_data), .ofifo_wrreq(ofifo_wrreq), .ofifo_full(ofifo_full),
    .fail_count(fail_count), .timeout_count(timeout_count)
  );

  initial forever #5 clock = ~clock;

  logic [15:0] mem [logic [19:0]];

  int total = 0;
  int bad = 0;

  // stimulus knobs, written only by the main sequence
  int stall_cfg = 0;
  bit rand_full = 1'b0;
  int full_arm_id = 0;

  // monitor-owned observations
  logic [19:0] addr_log [$];
  logic [30:0] out_log [$];
  int acc_cnt = 0, done_cnt = 0, rd_cycles = 0, stall_cycles = 0, full_cycles = 0;
  int hold_viol = 0, full_viol = 0;
  bit prev_stall = 1'b0, prev_fullp = 1'b0;
  logic [19:0] held_addr = '0;
  logic [30:0] held_data = '0;

  // slave-driver-owned state
  int seen_acc = 0, used_id = 0, stall_left = 0, full_hold = 0;
  bit reload = 1'b1;

  // reference results
  logic [30:0] exp_out [$];
  logic [19:0] exp_addr [$];
  bit exp_end;
  int exp_fail, exp_to;

  typedef struct {
    logic [19:0] base;
    int num;
    int stall;
    bit rfull;
    int end_at;
    bit poke;
    int exp_recs;
    bit exp_end;
    int exp_lat;
  } vec_t;
  vec_t vt [5];

  function automatic logic [15:0] rd_mem(input logic [19:0] a);
    return mem.exists(a) ? mem[a] : 16'h0000;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Memory slave and FIFO-full source; inputs change 1 time unit after the rising edge.
  always @(posedge clock) begin
    #1;
    if (acc_cnt != seen_acc) begin
      seen_acc = acc_cnt;
      reload = 1'b1;
      if ((acc_cnt % 2) == 0 && full_arm_id != used_id) begin
        used_id = full_arm_id;
        full_hold = 5;
      end
    end
    if (mem_read && reload) begin
      stall_left = (stall_cfg < 0) ? int'($urandom_range(0, 2)) : stall_cfg;
      reload = 1'b0;
    end
    mem_waitrequest = mem_read && (stall_left > 0);
    if (mem_waitrequest) stall_left--;
    mem_readdata = rd_mem(mem_address);
    if (full_hold > 0) begin
      ofifo_full = 1'b1;
      full_hold--;
    end else begin
      ofifo_full = rand_full ? ($urandom_range(0, 2) == 0) : 1'b0;
    end
  end

  // Observation on the falling edge.
  always @(negedge clock) begin
    if (!reset_n) begin
      prev_stall = 1'b0;
      prev_fullp = 1'b0;
    end else begin
      if (prev_stall && mem_read && mem_address != held_addr) hold_viol++;
      prev_stall = mem_read && mem_waitrequest;
      held_addr = mem_address;
      if (mem_read) rd_cycles++;
      if (mem_read && mem_waitrequest) stall_cycles++;
      if (mem_read && !mem_waitrequest) begin
        addr_log.push_back(mem_address);
        acc_cnt++;
      end
      if (ofifo_wrreq) out_log.push_back(ofifo_data);
      if (done) done_cnt++;
      if (busy && !mem_read && !done && ofifo_full) begin
        full_cycles++;
        if (ofifo_wrreq) full_viol++;
        if (prev_fullp && ofifo_data != held_data) full_viol++;
        prev_fullp = 1'b1;
      end else begin
        prev_fullp = 1'b0;
      end
      held_data = ofifo_data;
    end
  end

  task automatic fill(input logic [19:0] base, input int num, input int end_at);
    logic [19:0] a;
    logic [15:0] w1;
    for (int i = 0; i < num; i++) begin
      a = base + 20'(2*i);
      mem[a] = 16'($urandom);
      w1 = 16'($urandom);
      w1[7] = (i != end_at);
      mem[a + 20'd1] = w1;
    end
  endtask

  // Record-level model: walk the records, stop at the first cleared run bit.
  task automatic model(input logic [19:0] base, input int num);
    logic [19:0] a;
    logic [15:0] w0, w1;
    logic [23:0] rv;
    exp_out.delete();
    exp_addr.delete();
    exp_end = 1'b0;
    exp_fail = 0;
    exp_to = 0;
    for (int i = 0; i < num; i++) begin
      a = base + 20'(2*i);
      w0 = rd_mem(a);
      w1 = rd_mem(a + 20'd1);
      exp_addr.push_back(a);
      exp_addr.push_back(a + 20'd1);
      if (!w1[7]) begin
        exp_end = 1'b1;
        break;
      end
      rv = {w0, w1[15:8]};
      exp_out.push_back({w1[6], w1[5:1], w1[0], rv});
      exp_fail += int'(w1[0]);
      exp_to += int'(w1[6]);
    end
  endtask

  task automatic run(input logic [19:0] base, input int num, input bit poke, output int lat);
    int ai, oi, di, hv, fv, cyc;
    model(base, num);
    ai = addr_log.size();
    oi = out_log.size();
    di = done_cnt;
    hv = hold_viol;
    fv = full_viol;
    @(posedge clock); #2;
    base_address = base;
    num_records = 16'(num);
    start = 1'b1;
    @(posedge clock); #2;
    start = 1'b0;
    cyc = 0;
    while (done_cnt == di && cyc < 3000) begin
      @(negedge clock); #1;
      cyc++;
      if (poke && cyc == 3) begin
        start = 1'b1;
        base_address = base + 20'h40;
        num_records = 16'd7;
      end else if (poke && cyc == 4) begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    check("done_seen", 64'(done_cnt > di), 64'(1));
    lat = cyc;
    @(negedge clock); #1;
    check("done_pulses", 64'(done_cnt - di), 64'(1));
    check("busy_after", 64'(busy), 64'(0));
    check("out_count", 64'(out_log.size() - oi), 64'(exp_out.size()));
    for (int i = 0; i < exp_out.size() && oi + i < out_log.size(); i++)
      check("out_word", 64'(out_log[oi + i]), 64'(exp_out[i]));
    check("addr_count", 64'(addr_log.size() - ai), 64'(exp_addr.size()));
    for (int i = 0; i < exp_addr.size() && ai + i < addr_log.size(); i++)
      check("rd_addr", 64'(addr_log[ai + i]), 64'(exp_addr[i]));
    check("records_done", 64'(records_done), 64'(exp_out.size()));
    check("end_marker", 64'(end_marker), 64'(exp_end));
`ifdef RESULT_STATS_EN
    check("fail_count", 64'(fail_count), 64'(exp_fail));
    check("timeout_count", 64'(timeout_count), 64'(exp_to));
`else
    check("fail_count", 64'(fail_count), 64'(0));
    check("timeout_count", 64'(timeout_count), 64'(0));
`endif
    check("addr_hold", 64'(hold_viol - hv), 64'(0));
    check("full_hold", 64'(full_viol - fv), 64'(0));
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, ai, di, ri, sc, fc, cyc;
    logic [19:0] b;

    vt[0] = '{20'h00300, 4, 0,  1'b0, -1, 1'b0, 4, 1'b0, 13};
    vt[1] = '{20'hFFFFD, 3, 1,  1'b0, -1, 1'b0, 3, 1'b0, -1};
    vt[2] = '{20'h00400, 5, -1, 1'b1, 2,  1'b0, 2, 1'b1, -1};
    vt[3] = '{20'h00500, 4, 0,  1'b0, 0,  1'b0, 0, 1'b1, -1};
    vt[4] = '{20'h00600, 3, 0,  1'b0, -1, 1'b1, 3, 1'b0, -1};

    repeat (3) @(posedge clock);
    @(negedge clock); #1;
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_read", 64'(mem_read), 64'(0));
    check("rst_wrreq", 64'(ofifo_wrreq), 64'(0));
    check("rst_recs", 64'(records_done), 64'(0));
    check("rst_end", 64'(end_marker), 64'(0));
    check("rst_addr", 64'(mem_address), 64'(0));
    check("rst_be", 64'(mem_byteenable), 64'(2'b11));
    check("rst_fail", 64'(fail_count), 64'(0));
    check("rst_to", 64'(timeout_count), 64'(0));
    @(posedge clock); #2;
    reset_n = 1'b1;

    // single failing record at 0x100
    mem[20'h00100] = 16'hABCD;
    mem[20'h00101] = 16'hEF81;
    run(20'h00100, 1, 1'b0, lat);
    check("tp1_word", 64'(out_log[out_log.size() - 1]), 64'(31'h01ABCDEF));
    check("tp1_recs", 64'(records_done), 64'(1));
    check("tp1_lat", 64'(lat), 64'(4));

    // three records with a 2-cycle stall on every read
    stall_cfg = 2;
    fill(20'h00200, 3, -1);
    sc = stall_cycles;
    run(20'h00200, 3, 1'b0, lat);
    check("tp2_stalls", 64'(stall_cycles - sc), 64'(12));
    stall_cfg = 0;

    // zero records: no reads, quick done
    ri = rd_cycles;
    run(20'h00250, 0, 1'b0, lat);
    check("tp3_noread", 64'(rd_cycles - ri), 64'(0));
    check("tp3_lat", 64'(lat <= 2), 64'(1));

    // run bit cleared in the second record
    fill(20'h00900, 4, -1);
    mem[20'h00903] = 16'h1200;
    run(20'h00900, 4, 1'b0, lat);
    check("tp4_writes", 64'(records_done), 64'(1));
    check("tp4_end", 64'(end_marker), 64'(1));

    // FIFO full held for 5 cycles on the first PUSH
    fill(20'h00800, 2, -1);
    full_arm_id++;
    fc = full_cycles;
    run(20'h00800, 2, 1'b0, lat);
    check("tp5_full_cycles", 64'(full_cycles - fc), 64'(5));
    check("tp5_lat", 64'(lat), 64'(12));

    // table vectors
    for (int i = 0; i < 5; i++) begin
      stall_cfg = vt[i].stall;
      rand_full = vt[i].rfull;
      fill(vt[i].base, vt[i].num, vt[i].end_at);
      run(vt[i].base, vt[i].num, vt[i].poke, lat);
      check("vec_recs", 64'(records_done), 64'(vt[i].exp_recs));
      check("vec_end", 64'(end_marker), 64'(vt[i].exp_end));
      if (vt[i].exp_lat >= 0) check("vec_lat", 64'(lat), 64'(vt[i].exp_lat));
    end

    // randomized runs
    for (int i = 0; i < 8; i++) begin
      b = 20'($urandom);
      stall_cfg = -1;
      rand_full = 1'($urandom);
      fill(b, 6, ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 5)) : -1);
      run(b, int'($urandom_range(1, 6)), 1'b0, lat);
    end
    rand_full = 1'b0;

    // reset while stalled in the second record's word1 read
    stall_cfg = 2;
    fill(20'h00700, 2, -1);
    ai = addr_log.size();
    di = done_cnt;
    @(posedge clock); #2;
    base_address = 20'h00700;
    num_records = 16'd2;
    start = 1'b1;
    @(posedge clock); #2;
    start = 1'b0;
    cyc = 0;
    while (addr_log.size() < ai + 3 && cyc < 200) begin
      @(negedge clock); #1;
      cyc++;
    end
    check("rst_reach", 64'(addr_log.size() >= ai + 3), 64'(1));
    @(negedge clock); #1;
    check("rst_pre_recs", 64'(records_done), 64'(1));
    check("rst_pre_read", 64'(mem_read), 64'(1));
    reset_n = 1'b0;
    #1;
    check("rst_mid_busy", 64'(busy), 64'(0));
    check("rst_mid_recs", 64'(records_done), 64'(0));
    check("rst_mid_read", 64'(mem_read), 64'(0));
    repeat (2) @(posedge clock);
    #2;
    reset_n = 1'b1;
    @(negedge clock); #1;
    check("rst_no_done", 64'(done_cnt - di), 64'(0));
    run(20'h00700, 2, 1'b0, lat);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
